// File: rtl/nco_spi_regfile.sv
// nco_spi_regfile: SPI mode-0 slave that decodes framed writes into NUM_CH NCO phase registers.
// Define NCO_SPI_READBACK_EN to add MISO readback of the selected register.
module nco_spi_regfile #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_SCLK,
  input  logic                     i_CS,
  input  logic                     i_MOSI,
  output logic                     o_MISO,
  output logic                     o_MISO_oe,
  output logic [NUM_CH*DATA_W-1:0] o_phase_inc,
  output logic [NUM_CH-1:0]        o_update,
  output logic                     o_error
);

  localparam int unsigned FrameLen = 8 + DATA_W;
  localparam int unsigned CntW     = $clog2(FrameLen + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCmd  = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // CS synchroniser resets to the inactive level so o_MISO_oe is low out of reset.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_q;
  logic                   csa_q;
  logic [SYNC_STAGES:0]   flush_q;
  logic                   armed_q;

  logic sclk_s;
  logic mosi_s;
  logic csa;
  logic sclk_rise;
  logic csa_rise;
  logic flushed;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_q      <= 1'b0;
      csa_q       <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
      sclk_q      <= sclk_s;
      csa_q       <= csa;
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      // Only a genuinely observed CS-high arms the slave; CS held low across reset stays ignored.
      if (flushed && !csa) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign csa       = ~cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign csa_rise  = csa & ~csa_q;
  assign flushed   = flush_q[SYNC_STAGES];

  // Frame FSM, bit counter and receive shift register.
  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              commit_q, commit_d;
  logic              abort_err;
  logic [7:0]        cmd_next;

  assign cmd_next = {rx_q[6:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    cmd_d     = cmd_q;
    commit_d  = 1'b0;
    abort_err = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (csa_rise && armed_q) begin
          state_d = StCmd;
        end
      end
      StCmd, StData: begin
        // CS release wins over an SCLK edge seen in the same cycle.
        if (!csa) begin
          state_d   = StIdle;
          cnt_d     = '0;
          abort_err = (cnt_q != '0);
        end else if (sclk_rise) begin
          rx_d  = {rx_q[DATA_W-2:0], mosi_s};
          cnt_d = cnt_q + CntW'(1);
          if ((state_q == StCmd) && (cnt_q == CntW'(7))) begin
            state_d = StData;
            cmd_d   = cmd_next;
          end else if ((state_q == StData) && (cnt_q == CntW'(FrameLen - 1))) begin
            state_d  = StDone;
            commit_d = cmd_q[7];
          end
        end
      end
      StDone: begin
        if (!csa) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rx_q     <= '0;
      cmd_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      cmd_q    <= cmd_d;
      commit_q <= commit_d;
    end
  end

  // Register file, update strobes and sticky error.
  logic [NUM_CH*DATA_W-1:0] phase_q;
  logic [NUM_CH-1:0]        update_q;
  logic                     error_q;
  logic                     ch_valid;
  logic                     rd_bad;

  assign ch_valid = ({25'd0, cmd_q[6:0]} < NUM_CH);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      phase_q  <= '0;
      update_q <= '0;
      error_q  <= 1'b0;
    end else begin
      update_q <= '0;
      if (commit_q) begin
        if (ch_valid) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (cmd_q[6:0] == 7'(k)) begin
              phase_q[k*DATA_W +: DATA_W] <= rx_q;
              update_q[k]                 <= 1'b1;
            end
          end
        end else begin
          error_q <= 1'b1;
        end
      end
      if (abort_err || rd_bad) begin
        error_q <= 1'b1;
      end
    end
  end

  assign o_phase_inc = phase_q;
  assign o_update    = update_q;
  assign o_error     = error_q;

`ifdef NCO_SPI_READBACK_EN
  logic              sclk_fall;
  logic              rd_load;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] tx_q;
  logic [CntW-1:0]   tx_cnt_q;
  logic              miso_q;

  assign sclk_fall = ~sclk_s & sclk_q;
  // Load on the 8th rise of a read command; same condition that moves CMD to DATA.
  assign rd_load   = (state_q == StCmd) && csa && sclk_rise && (cnt_q == CntW'(7)) &&
                     !cmd_next[7];
  assign rd_bad    = rd_load && !({25'd0, cmd_next[6:0]} < NUM_CH);

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cmd_next[6:0] == 7'(k)) begin
        rd_word = phase_q[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      tx_q     <= '0;
      tx_cnt_q <= '0;
      miso_q   <= 1'b0;
    end else if (!csa) begin
      tx_cnt_q <= '0;
      miso_q   <= 1'b0;
    end else if (rd_load) begin
      tx_q     <= rd_word;
      tx_cnt_q <= CntW'(DATA_W);
    end else if (sclk_fall) begin
      if (tx_cnt_q != '0) begin
        miso_q   <= tx_q[DATA_W-1];
        tx_q     <= {tx_q[DATA_W-2:0], 1'b0};
        tx_cnt_q <= tx_cnt_q - CntW'(1);
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  assign o_MISO    = miso_q;
  assign o_MISO_oe = csa;
`else
  assign rd_bad    = 1'b0;
  assign o_MISO    = 1'b0;
  assign o_MISO_oe = 1'b0;
`endif

endmodule

// File: tb/tb_nco_spi_regfile.sv
// Self-checking bench for nco_spi_regfile: directed SPI frames against a frame-level register model.
module tb_nco_spi_regfile;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned DATA_W   = 24;
  localparam int unsigned FrameLen = 8 + DATA_W;
  localparam int          HALF     = 8;   // i_clock cycles per SCLK half period
  localparam int          GAP      = 32;  // two SCLK periods of CS high between frames

  logic                     i_clock;
  logic                     i_reset_n;
  logic                     i_SCLK;
  logic                     i_CS;
  logic                     i_MOSI;
  logic                     o_MISO;
  logic                     o_MISO_oe;
  logic [NUM_CH*DATA_W-1:0] o_phase_inc;
  logic [NUM_CH-1:0]        o_update;
  logic                     o_error;

  nco_spi_regfile #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .SYNC_STAGES(2)
  ) dut (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_SCLK     (i_SCLK),
    .i_CS       (i_CS),
    .i_MOSI     (i_MOSI),
    .o_MISO     (o_MISO),
    .o_MISO_oe  (o_MISO_oe),
    .o_phase_inc(o_phase_inc),
    .o_update   (o_update),
    .o_error    (o_error)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Frame-level model: register contents, sticky error, expected strobes per channel.
  logic [DATA_W-1:0] exp_phase [NUM_CH];
  logic              exp_err;
  int                exp_pulses [NUM_CH];
  int                obs_pulses [NUM_CH];
  logic [NUM_CH-1:0] upd_log [$];
  logic [NUM_CH-1:0] prev_upd = '0;
  logic              settled  = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NUM_CH; k++) exp_phase[k] = '0;
    exp_err = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] cmd, input logic [31:0] data,
                                      input int nbits);
    int ch;
    ch = int'(cmd[6:0]);
    if (nbits == 0) return;
    if (nbits < FrameLen) begin
      exp_err = 1'b1;
      return;
    end
    if (cmd[7]) begin
      if (ch < NUM_CH) begin
        exp_phase[ch] = data[DATA_W-1:0];
        exp_pulses[ch]++;
      end else begin
        exp_err = 1'b1;
      end
    end else begin
`ifdef NCO_SPI_READBACK_EN
      if (ch >= NUM_CH) exp_err = 1'b1;
`endif
    end
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge i_clock) begin
    logic [NUM_CH*DATA_W-1:0] flat;
    if (o_update != '0) begin
      upd_log.push_back(o_update);
      for (int k = 0; k < NUM_CH; k++) if (o_update[k]) obs_pulses[k]++;
    end
    check("strobe_single_cycle", o_update & prev_upd, '0);
    check("strobe_onehot", ($countones(o_update) <= 1), 1);
    prev_upd = o_update;
    if (settled) begin
      for (int k = 0; k < NUM_CH; k++) flat[k*DATA_W +: DATA_W] = exp_phase[k];
      check("phase_vs_model", o_phase_inc, flat);
      check("error_vs_model", o_error, exp_err);
      check("update_idle", o_update, '0);
      check("miso_idle", {o_MISO, o_MISO_oe}, 2'b00);
    end
`ifndef NCO_SPI_READBACK_EN
    check("miso_tied_off", {o_MISO, o_MISO_oe}, 2'b00);
`endif
  end

  task automatic spi_bit(input logic b, output logic m);
    i_MOSI = b;
    repeat (HALF) @(negedge i_clock);
    m = o_MISO;
    i_SCLK = 1'b1;
    repeat (HALF) @(negedge i_clock);
    i_SCLK = 1'b0;
  endtask

  task automatic check_pulses(input string tag);
    for (int k = 0; k < NUM_CH; k++) check(tag, obs_pulses[k], exp_pulses[k]);
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                       output logic [31:0] miso_v, output logic oe_mid);
    logic [FrameLen-1:0] bits;
    logic m;
    bits    = {cmd, data[DATA_W-1:0]};
    miso_v  = '0;
    oe_mid  = 1'b0;
    settled = 1'b0;
    i_CS    = 1'b0;
    repeat (HALF) @(negedge i_clock);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(bits[FrameLen-1-i], m);
      miso_v[FrameLen-1-i] = m;
      if (i == 10) oe_mid = o_MISO_oe;
    end
    repeat (HALF) @(negedge i_clock);
    i_CS = 1'b1;
    repeat (GAP) @(negedge i_clock);
    model_frame(cmd, data, nbits);
    settled = 1'b1;
    @(negedge i_clock);
    check_pulses("pulse_count");
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {o_phase_inc, o_update, o_error, o_MISO, o_MISO_oe}, '0);
  endtask

  task automatic do_reset();
    settled   = 1'b0;
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clock);
    model_reset();
    check_reset_outputs("reset_outputs");
    i_reset_n = 1'b1;
    repeat (GAP) @(negedge i_clock);
    settled = 1'b1;
  endtask

  logic [31:0] mv;
  logic        oe;
  int          n0;

  initial begin
    logic [FrameLen-1:0] bits;
    logic m;
    for (int k = 0; k < NUM_CH; k++) begin
      exp_pulses[k] = 0;
      obs_pulses[k] = 0;
    end
    model_reset();
    i_reset_n = 1'b0;
    i_CS      = 1'b1;
    i_SCLK    = 1'b0;
    i_MOSI    = 1'b0;
    do_reset();

    // Plain write to channel 2.
    frame(8'h82, 32'h123456, FrameLen, mv, oe);
    check("t1_ch2", o_phase_inc[2*DATA_W +: DATA_W], 24'h123456);
    check("t1_others", {o_phase_inc[3*DATA_W +: DATA_W], o_phase_inc[0 +: 2*DATA_W]}, '0);
    check("t1_pulse_ch2", obs_pulses[2], 1);

    // Frame aborted after 20 bits.
    frame(8'h81, 32'h777777, 20, mv, oe);
    check("t2_error", o_error, 1'b1);
    check("t2_ch1", o_phase_inc[1*DATA_W +: DATA_W], '0);

    // Out-of-range channel after a good write.
    do_reset();
    frame(8'h81, 32'h0F0F0F, FrameLen, mv, oe);
    check("t3_no_error_yet", o_error, 1'b0);
    frame(8'h85, 32'hABCDEF, FrameLen, mv, oe);
    check("t3_error", o_error, 1'b1);
    check("t3_ch1_held", o_phase_inc[1*DATA_W +: DATA_W], 24'h0F0F0F);

    // Readback of channel 1; data clocked in during a read is discarded.
    do_reset();
    frame(8'h81, 32'hA5A5A5, FrameLen, mv, oe);
    frame(8'h01, 32'h5A5A5A, FrameLen, mv, oe);
    check("t4_ch1_kept", o_phase_inc[1*DATA_W +: DATA_W], 24'hA5A5A5);
`ifdef NCO_SPI_READBACK_EN
    check("t4_rb_data", mv[DATA_W-1:0], 24'hA5A5A5);
    check("t4_rb_cmd_phase", mv[31:24], 8'h00);
    check("t4_rb_oe", oe, 1'b1);
    check("t4_rb_no_error", o_error, 1'b0);
    frame(8'h07, 32'h000000, FrameLen, mv, oe);
    check("t4_rb_bad_data", mv, '0);
    check("t4_rb_bad_error", o_error, 1'b1);
`else
    check("t4_no_rb_data", mv, '0);
    check("t4_no_rb_oe", oe, 1'b0);
    frame(8'h07, 32'h000000, FrameLen, mv, oe);
    check("t4_no_rb_bad_no_error", o_error, 1'b0);
`endif

    // Reset mid-frame with CS still low at release.
    do_reset();
    settled = 1'b0;
    bits = {8'h82, 24'h123456};
    i_CS = 1'b0;
    repeat (HALF) @(negedge i_clock);
    for (int i = 0; i < 12; i++) spi_bit(bits[FrameLen-1-i], m);
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clock);
    model_reset();
    check_reset_outputs("t5_in_reset");
    i_reset_n = 1'b1;
    for (int i = 12; i < FrameLen; i++) spi_bit(bits[FrameLen-1-i], m);
    repeat (HALF) @(negedge i_clock);
    i_CS = 1'b1;
    repeat (GAP) @(negedge i_clock);
    settled = 1'b1;
    @(negedge i_clock);
    check("t5_regs_zero", o_phase_inc, '0);
    check("t5_error_zero", o_error, 1'b0);
    check_pulses("t5_pulse_count");
    frame(8'h82, 32'h654321, FrameLen, mv, oe);
    check("t5_next_frame", o_phase_inc[2*DATA_W +: DATA_W], 24'h654321);

    // Back-to-back writes give two separate strobes in order.
    n0 = upd_log.size();
    frame(8'h80, 32'h000001, FrameLen, mv, oe);
    frame(8'h83, 32'hFFFFFF, FrameLen, mv, oe);
    check("t6_pulse_total", upd_log.size() - n0, 2);
    check("t6_first_ch0", upd_log[n0], 4'b0001);
    check("t6_second_ch3", upd_log[n0+1], 4'b1000);
    check("t6_ch0", o_phase_inc[0 +: DATA_W], 24'h000001);
    check("t6_ch3", o_phase_inc[3*DATA_W +: DATA_W], 24'hFFFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
